// File: rtl/clcd_pkg.sv
// ---------------------------------------------------------------------------
// clcd_pkg
// Shared types and constants for the character-LCD command sequencer.
//   state_t            : sequencer FSM states (exported on the debug port)
//   init_entry_t       : one power-up table entry {rs, data, post_delay_ms}
//   LCD_*              : HD44780-style command bytes used by the init table
//   DEFAULT_INIT_TABLE : nine-entry 4-bit-mode power-up sequence
//   init_entry()       : table lookup; indices past the table repeat the
//                        final (idempotent) display-on entry
// ---------------------------------------------------------------------------
package clcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP     = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACK  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_DELAY     = 3'd4,
        ST_IDLE      = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
        logic [6:0] post_delay_ms;
    } init_entry_t;

    localparam logic [7:0] LCD_FUNC_SET_8BIT   = 8'h30;
    localparam logic [7:0] LCD_FUNC_SET_4BIT   = 8'h02;
    localparam logic [7:0] LCD_FUNC_4BIT_2LINE = 8'h28;
    localparam logic [7:0] LCD_DISPLAY_OFF     = 8'h08;
    localparam logic [7:0] LCD_CLEAR           = 8'h01;
    localparam logic [7:0] LCD_ENTRY_INC       = 8'h06;
    localparam logic [7:0] LCD_DISPLAY_ON_BLK  = 8'h0F;

    localparam int INIT_TABLE_MAX = 32;

    localparam init_entry_t DEFAULT_INIT_TABLE [0:8] = '{
        '{1'b0, LCD_FUNC_SET_8BIT,   7'd5},
        '{1'b0, LCD_FUNC_SET_8BIT,   7'd1},
        '{1'b0, LCD_FUNC_SET_8BIT,   7'd1},
        '{1'b0, LCD_FUNC_SET_4BIT,   7'd1},
        '{1'b0, LCD_FUNC_4BIT_2LINE, 7'd1},
        '{1'b0, LCD_DISPLAY_OFF,     7'd1},
        '{1'b0, LCD_CLEAR,           7'd2},
        '{1'b0, LCD_ENTRY_INC,       7'd1},
        '{1'b0, LCD_DISPLAY_ON_BLK,  7'd1}
    };

    function automatic init_entry_t init_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    return DEFAULT_INIT_TABLE[0];
            5'd1:    return DEFAULT_INIT_TABLE[1];
            5'd2:    return DEFAULT_INIT_TABLE[2];
            5'd3:    return DEFAULT_INIT_TABLE[3];
            5'd4:    return DEFAULT_INIT_TABLE[4];
            5'd5:    return DEFAULT_INIT_TABLE[5];
            5'd6:    return DEFAULT_INIT_TABLE[6];
            5'd7:    return DEFAULT_INIT_TABLE[7];
            default: return DEFAULT_INIT_TABLE[8];
        endcase
    endfunction

endpackage

// File: rtl/clcd_tick_gen.sv
// ---------------------------------------------------------------------------
// clcd_tick_gen
// Free-running time base: single-cycle 1 us and 1 ms pulses derived from the
// system clock. The divider is never restarted by the consumer, so a delay
// started at an arbitrary point may see its first tick early; consumers
// account for that themselves.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (counters to 0)
//   us_tick  out high for one cycle every microsecond
//   ms_tick  out high for one cycle every 1000 us_tick pulses (coincides
//                with the us_tick that completes the millisecond)
// At CLK_FREQ_HZ = 1 MHz us_tick is continuously high (one tick per cycle).
// ---------------------------------------------------------------------------
module clcd_tick_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic us_tick,
    output logic ms_tick
);

    localparam int unsigned DIV  = (CLK_FREQ_HZ >= 1_000_000) ? (CLK_FREQ_HZ / 1_000_000) : 1;
    localparam int          US_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [US_W-1:0] US_LAST = US_W'(DIV - 1);
    localparam logic [9:0]      MS_LAST = 10'd999;

    logic [US_W-1:0] us_cnt;
    logic [9:0]      ms_cnt;

    assign us_tick = (us_cnt == US_LAST);
    assign ms_tick = us_tick && (ms_cnt == MS_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            us_cnt <= '0;
            ms_cnt <= '0;
        end else begin
            if (us_tick) begin
                us_cnt <= '0;
                ms_cnt <= (ms_cnt == MS_LAST) ? 10'd0 : ms_cnt + 10'd1;
            end else begin
                us_cnt <= us_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clcd_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// clcd_cmd_sequencer
// Drives a character LCD through a byte-wide transmitter: waits for power-up,
// replays the init table, then forwards user writes, each followed by a
// settle delay.
//
// Optional feature: define CLCD_SEQ_BUSY_TIMEOUT_EN to bound every wait for an
// i_busy edge by BUSY_TIMEOUT_US; on expiry o_error latches, o_valid drops and
// the FSM parks in FAULT until reset. Without the macro the FSM waits forever
// and o_error is tied low.
//
// Handshakes:
//   Transmitter side: o_valid rises with o_data/o_RS and holds them stable
//   until a rising edge of i_busy is sampled; o_valid falls the next cycle.
//   Completion is the sampled falling edge of i_busy. Edges outside the
//   wait states, or too short to be sampled, are ignored.
//   User side: a write transfers on a clock edge where i_wr_valid and
//   o_wr_ready are both high. o_wr_ready is high only in IDLE, which is
//   entered after the init table has completed.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   i_busy                    transmitter busy
//   o_data, o_RS, o_RW        byte, register select, read/write (always 0)
//   o_valid                   byte request to the transmitter
//   o_init_done               init table finished (sticky until reset)
//   i_wr_valid/i_wr_rs/i_wr_data, o_wr_ready   user write port
//   o_error                   sticky busy-timeout flag
//   dbg_state                 current FSM state
// ---------------------------------------------------------------------------
module clcd_cmd_sequencer
    import clcd_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
    parameter int unsigned N_INIT          = 9,
    parameter int unsigned POWERUP_MS      = 20,
    parameter int unsigned USR_DELAY_US    = 50,
    parameter int unsigned BUSY_TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_busy,
    output logic [7:0] o_data,
    output logic       o_RS,
    output logic       o_RW,
    output logic       o_valid,
    output logic       o_init_done,
    input  logic       i_wr_valid,
    input  logic       i_wr_rs,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ready,
    output logic       o_error,
    output state_t     dbg_state
);

    localparam int          PW_W     = (POWERUP_MS > 1) ? $clog2(POWERUP_MS) : 1;
    localparam logic [PW_W-1:0] PWR_LAST = PW_W'(POWERUP_MS - 1);
    localparam logic [4:0]  IDX_LAST = 5'(N_INIT - 1);
    localparam logic [23:0] USR_DLY  = 24'(USR_DELAY_US);

    state_t            state;
    logic [4:0]        idx;
    logic [PW_W-1:0]   pwr_cnt;
    logic [23:0]       dly_cnt;
    logic [23:0]       dly_target;
    logic              dly_done;
    logic              busy_q;
    logic              busy_rise;
    logic              busy_fall;
    logic              usr_op;
    logic              usr_rs;
    logic [7:0]        usr_data;
    init_entry_t       cur_entry;
    logic              us_tick;
    logic              ms_tick;

    clcd_tick_gen #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .us_tick (us_tick),
        .ms_tick (ms_tick)
    );

    assign cur_entry = init_entry(idx);
    assign busy_rise = i_busy && !busy_q;
    assign busy_fall = !i_busy && busy_q;

    // Millisecond delays are counted in microseconds so the free-running
    // divider can only lengthen a delay by one tick, never shorten it by a
    // whole millisecond.
    assign dly_target = usr_op ? USR_DLY : (24'(cur_entry.post_delay_ms) * 24'd1000);
    assign dly_done   = (dly_cnt >= dly_target) ||
                        (us_tick && ((dly_cnt + 24'd1) >= dly_target));

    assign o_RW      = 1'b0;
    assign dbg_state = state;

`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
    localparam int          TO_W    = (BUSY_TIMEOUT_US > 1) ? $clog2(BUSY_TIMEOUT_US) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT_US - 1);
    logic [TO_W-1:0] to_cnt;
    logic            error_q;
    logic            to_hit;
    assign to_hit  = us_tick && (to_cnt == TO_LAST);
    assign o_error = error_q;
`else
    logic unused_cfg;
    assign unused_cfg = (BUSY_TIMEOUT_US != 0);
    assign o_error    = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_PWRUP;
            idx         <= '0;
            pwr_cnt     <= '0;
            dly_cnt     <= '0;
            busy_q      <= 1'b0;
            usr_op      <= 1'b0;
            usr_rs      <= 1'b0;
            usr_data    <= '0;
            o_data      <= '0;
            o_RS        <= 1'b0;
            o_valid     <= 1'b0;
            o_init_done <= 1'b0;
            o_wr_ready  <= 1'b0;
`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
            to_cnt      <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            busy_q <= i_busy;
            case (state)
                ST_PWRUP: begin
                    if (ms_tick) begin
                        if (pwr_cnt == PWR_LAST) begin
                            state  <= ST_ISSUE;
                            idx    <= '0;
                            usr_op <= 1'b0;
                        end else begin
                            pwr_cnt <= pwr_cnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    o_data  <= usr_op ? usr_data : cur_entry.data;
                    o_RS    <= usr_op ? usr_rs   : cur_entry.rs;
                    o_valid <= 1'b1;
                    state   <= ST_WAIT_ACK;
`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
                    to_cnt  <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    if (busy_rise) begin
                        o_valid <= 1'b0;
                        state   <= ST_WAIT_DONE;
`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
                        to_cnt  <= '0;
                    end else if (to_hit) begin
                        o_valid <= 1'b0;
                        error_q <= 1'b1;
                        state   <= ST_FAULT;
                    end else if (us_tick) begin
                        to_cnt  <= to_cnt + 1'b1;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (busy_fall) begin
                        dly_cnt <= '0;
                        state   <= ST_DELAY;
`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
                    end else if (to_hit) begin
                        error_q <= 1'b1;
                        state   <= ST_FAULT;
                    end else if (us_tick) begin
                        to_cnt  <= to_cnt + 1'b1;
`endif
                    end
                end
                ST_DELAY: begin
                    if (dly_done) begin
                        if (usr_op || (idx == IDX_LAST)) begin
                            o_init_done <= 1'b1;
                            o_wr_ready  <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= ST_ISSUE;
                        end
                    end else if (us_tick) begin
                        dly_cnt <= dly_cnt + 24'd1;
                    end
                end
                ST_IDLE: begin
                    if (i_wr_valid && o_wr_ready) begin
                        usr_rs     <= i_wr_rs;
                        usr_data   <= i_wr_data;
                        usr_op     <= 1'b1;
                        o_wr_ready <= 1'b0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_FAULT: begin
                    // Parked until reset.
                end
                default: begin
                    state <= ST_PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clcd_cmd_sequencer.sv
module tb_clcd_cmd_sequencer;
    import clcd_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       i_busy;
    logic [7:0] o_data;
    logic       o_RS;
    logic       o_RW;
    logic       o_valid;
    logic       o_init_done;
    logic       i_wr_valid;
    logic       i_wr_rs;
    logic [7:0] i_wr_data;
    logic       o_wr_ready;
    logic       o_error;
    state_t     dbg_state;

    clcd_cmd_sequencer #(
        .CLK_FREQ_HZ     (1_000_000),
        .N_INIT          (9),
        .POWERUP_MS      (2),
        .USR_DELAY_US    (50),
        .BUSY_TIMEOUT_US (100)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_busy      (i_busy),
        .o_data      (o_data),
        .o_RS        (o_RS),
        .o_RW        (o_RW),
        .o_valid     (o_valid),
        .o_init_done (o_init_done),
        .i_wr_valid  (i_wr_valid),
        .i_wr_rs     (i_wr_rs),
        .i_wr_data   (i_wr_data),
        .o_wr_ready  (o_wr_ready),
        .o_error     (o_error),
        .dbg_state   (dbg_state)
    );

    // Cycles since reset release (value after the k-th rising edge is k).
    int cyc;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] exp_q[$];
    logic [8:0] init_ref [9] = '{9'h030, 9'h030, 9'h030, 9'h002, 9'h028,
                                 9'h008, 9'h001, 9'h006, 9'h00F};
    int   last_fall_cyc = 0;
    int   n_txn = 0;
    logic model_en = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic load_init();
        exp_q.delete();
        foreach (init_ref[i]) exp_q.push_back(init_ref[i]);
    endtask

    // ---------------- transmitter model ----------------
    // Raises busy 3 cycles after it sees o_valid, keeps it high for 10 cycles.
    initial begin
        i_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && reset_n && o_valid) begin
                repeat (3) @(negedge clk);
                i_busy = 1'b1;
                check("valid_hold_until_busy", o_valid, 1);
                @(negedge clk);
                check("valid_drop_after_busy", o_valid, 0);
                repeat (9) @(negedge clk);
                i_busy = 1'b0;
                last_fall_cyc = cyc;
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic       prev_valid;
        logic [8:0] held;
        logic [8:0] exp;
        prev_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_valid = 1'b0;
                n_txn = 0;
            end else begin
                if (o_valid && !prev_valid) begin
                    n_txn++;
                    held = {o_RS, o_data};
                    check("txn_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        exp = exp_q.pop_front();
                        check("txn_rs_data", 32'(held), 32'(exp));
                    end
                    check("rw_zero", o_RW, 0);
                end else if (o_valid) begin
                    check("txn_stable", 32'({o_RS, o_data}), 32'(held));
                end
                prev_valid = o_valid;
            end
        end
    end

    // ---------------- user-port driver ----------------
    task automatic user_write(input logic rs, input logic [7:0] data);
        int w;
        i_wr_rs    = rs;
        i_wr_data  = data;
        i_wr_valid = 1'b1;
        w = 0;
        while (!o_wr_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("wr_accept_wait", o_wr_ready, 1);
        if (o_wr_ready) begin
            exp_q.push_back({rs, data});
            @(posedge clk);
            #1 i_wr_valid = 1'b0;
            @(negedge clk);
            check("wr_ready_fall", o_wr_ready, 0);
        end else begin
            i_wr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!o_wr_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("idle_return", o_wr_ready, 1);
        check_range("usr_settle_delay", cyc - last_fall_cyc, 50, 51);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   w;
        int   t0;
        logic early_leak;
        logic       early_rs;
        logic [7:0] early_data;

        early_rs   = 1'($urandom_range(0, 1));
        early_data = 8'($urandom_range(0, 255));
        reset_n    = 1'b0;
        i_wr_valid = 1'b1;
        i_wr_rs    = early_rs;
        i_wr_data  = early_data;
        load_init();

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_data", o_data, 0);
        check("rst_rs", o_RS, 0);
        check("rst_rw", o_RW, 0);
        check("rst_valid", o_valid, 0);
        check("rst_init_done", o_init_done, 0);
        check("rst_wr_ready", o_wr_ready, 0);
        check("rst_error", o_error, 0);
        check("rst_state", 32'(dbg_state), 32'(ST_PWRUP));

        // Power-up latency to the first request.
        reset_n = 1'b1;
        w = 0;
        while (!o_valid && w < 2100) begin
            @(negedge clk);
            w++;
        end
        check_range("pwrup_latency", cyc, 2000, 2001);
        check("first_byte", o_data, 8'h30);

        // Whole init table with the user write held high throughout.
        early_leak = 1'b0;
        w = 0;
        while (!o_init_done && w < 20000) begin
            @(negedge clk);
            if (o_wr_ready && !o_init_done) early_leak = 1'b1;
            w++;
        end
        check("init_done", o_init_done, 1);
        check("init_table_consumed", 32'(exp_q.size()), 0);
        check_range("init_done_after_last_delay", cyc - last_fall_cyc, 1000, 1001);
        check("early_write_gated", early_leak, 0);
        check("idle_ready", o_wr_ready, 1);
        check("idle_state", 32'(dbg_state), 32'(ST_IDLE));

        // Early write is taken in the first IDLE cycle.
        exp_q.push_back({early_rs, early_data});
        @(posedge clk);
        #1 i_wr_valid = 1'b0;
        @(negedge clk);
        check("early_accept_ready_fall", o_wr_ready, 0);
        check("early_accept_state", 32'(dbg_state), 32'(ST_ISSUE));
        wait_idle();

        // Directed data write 'A'.
        user_write(1'b1, 8'h41);
        wait_idle();

        // Randomized user writes.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            user_write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            wait_idle();
        end
        check("user_txns_consumed", 32'(exp_q.size()), 0);
        check("init_done_sticky", o_init_done, 1);
        check("no_error", o_error, 0);

        // Reset in WAIT_DONE of entry 4.
        reset_n = 1'b0;
        load_init();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        w = 0;
        while (!(n_txn == 5 && dbg_state == ST_WAIT_DONE) && w < 15000) begin
            @(negedge clk);
            w++;
        end
        check("reach_entry4_wait_done", 32'(n_txn == 5 && dbg_state == ST_WAIT_DONE), 1);
        reset_n  = 1'b0;
        model_en = 1'b0;
        #1;
        check("midrst_data", o_data, 0);
        check("midrst_rs", o_RS, 0);
        check("midrst_valid", o_valid, 0);
        check("midrst_init_done", o_init_done, 0);
        check("midrst_wr_ready", o_wr_ready, 0);
        check("midrst_error", o_error, 0);
        check("midrst_state", 32'(dbg_state), 32'(ST_PWRUP));
        load_init();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        w = 0;
        while (!o_valid && w < 2100) begin
            @(negedge clk);
            w++;
        end
        t0 = cyc;
        check("restart_valid", o_valid, 1);
        check("restart_entry0", o_data, 8'h30);

        // A busy pulse too short to be sampled must not complete the request.
        repeat (10) @(negedge clk);
        i_busy = 1'b1;
        #1 i_busy = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_state", 32'(dbg_state), 32'(ST_WAIT_ACK));
        check("glitch_valid_held", o_valid, 1);

`ifdef CLCD_SEQ_BUSY_TIMEOUT_EN
        w = 0;
        while (o_valid && w < 300) begin
            @(negedge clk);
            w++;
        end
        check_range("timeout_latency", cyc - t0, 100, 101);
        check("timeout_error", o_error, 1);
        check("timeout_valid", o_valid, 0);
        check("timeout_state", 32'(dbg_state), 32'(ST_FAULT));
        repeat (50) @(negedge clk);
        check("fault_held_state", 32'(dbg_state), 32'(ST_FAULT));
        check("fault_held_error", o_error, 1);
`else
        repeat (300) @(negedge clk);
        check("no_timeout_valid", o_valid, 1);
        check("no_timeout_error", o_error, 0);
        check("no_timeout_state", 32'(dbg_state), 32'(ST_WAIT_ACK));
        check_range("no_timeout_elapsed", cyc - t0, 300, 400);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
